// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared pipeline types, forwarding select encodings and match helpers.
package hazard_fwd_ctrl_pkg;
  localparam logic [1:0] SEL_RF     = 2'd0;
  localparam logic [1:0] SEL_P3_ALU = 2'd1;
  localparam logic [1:0] SEL_P4_ALU = 2'd2;
  localparam logic [1:0] SEL_P4_LD  = 2'd3;
  typedef logic [2:0] reg_t;
  typedef struct packed {
    logic valid;
    reg_t alu_rd;
    logic alu_we;
    reg_t mem_rd;
    logic load_we;
  } stage_t;
  typedef struct packed {
    stage_t s;
    reg_t   alu_rn;
    reg_t   alu_rm;
    reg_t   mem_rn;
    logic   use_rn;
    logic   use_rm;
    logic   use_mem_rn;
    logic   store;
  } p2_t;
  function automatic logic alu_hit(stage_t s, reg_t r);
    return s.valid && s.alu_we && s.alu_rd == r;
  endfunction
  // a load whose rd is also written by the ALU slot of the same packet is overridden
  function automatic logic ld_eff(stage_t s, reg_t r);
    return s.valid && s.load_we && s.mem_rd == r && !(s.alu_we && s.alu_rd == s.mem_rd);
  endfunction
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: decode packet inputs and hazard/forwarding outputs.
interface hazard_fwd_ctrl_if
  import hazard_fwd_ctrl_pkg::*;
#(parameter int CNT_W = 16);
  logic             p1_valid;
  reg_t             p1_alu_rn, p1_alu_rm, p1_alu_rd;
  logic             p1_alu_useRm, p1_alu_regWrite;
  reg_t             p1_mem_rn, p1_mem_rd;
  logic             p1_memRead, p1_memWrite;
  logic             flush;
  logic             stall, bubble_p2;
  logic [1:0]       f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
  logic             f_mem_reg_rd_sel;
  logic             dual_write_err;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output p1_valid, p1_alu_rn, p1_alu_rm, p1_alu_rd, p1_alu_useRm, p1_alu_regWrite,
           p1_mem_rn, p1_mem_rd, p1_memRead, p1_memWrite, flush,
    input  stall, bubble_p2, f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel,
           f_mem_reg_rd_sel, dual_write_err, stall_count
  );
  modport slave (
    input  p1_valid, p1_alu_rn, p1_alu_rm, p1_alu_rd, p1_alu_useRm, p1_alu_regWrite,
           p1_mem_rn, p1_mem_rd, p1_memRead, p1_memWrite, flush,
    output stall, bubble_p2, f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel,
           f_mem_reg_rd_sel, dual_write_err, stall_count
  );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: EX-stage operand source select for one register read.
module fwd_select
  import hazard_fwd_ctrl_pkg::*;
(
  input  reg_t       src,
  input  logic       use_src,
  input  stage_t     p3,
  input  stage_t     p4,
  output logic [1:0] sel
);
  logic unused_p3;
  assign unused_p3 = ^{p3.mem_rd, p3.load_we};
  always_comb
    sel = !use_src           ? SEL_RF     :
          alu_hit(p3, src)   ? SEL_P3_ALU :
          alu_hit(p4, src)   ? SEL_P4_ALU :
          ld_eff(p4, src)    ? SEL_P4_LD  : SEL_RF;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use / store-data stall detection, EX forwarding selects and stall counter.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(parameter int CNT_W = 16)
(
  input logic              clk,
  input logic              reset,
  hazard_fwd_ctrl_if.slave bus
);
  p2_t              p2, p2_nxt;
  stage_t           p3, p4;
  logic [CNT_W-1:0] cnt;
  logic             mem_acc, ld_use, st_data, stall, bubble;
  always_comb begin
    mem_acc = bus.p1_memRead | bus.p1_memWrite;
    ld_use  = ld_eff(p2.s, bus.p1_alu_rn) | (bus.p1_alu_useRm & ld_eff(p2.s, bus.p1_alu_rm)) |
              (mem_acc & ld_eff(p2.s, bus.p1_mem_rn));
    // store data can only be forwarded from a p3 ALU result once the store is in EX
    st_data = bus.p1_memWrite & (ld_eff(p2.s, bus.p1_mem_rd) | alu_hit(p3, bus.p1_mem_rd) |
              ld_eff(p3, bus.p1_mem_rd));
    stall   = bus.p1_valid & ~bus.flush & (ld_use | st_data);
    bubble  = stall | bus.flush;
    p2_nxt  = '0;
    if (bus.p1_valid && !bubble)
      p2_nxt = '{s: '{1'b1, bus.p1_alu_rd, bus.p1_alu_regWrite, bus.p1_mem_rd, bus.p1_memRead},
                 alu_rn: bus.p1_alu_rn, alu_rm: bus.p1_alu_rm, mem_rn: bus.p1_mem_rn,
                 use_rn: 1'b1, use_rm: bus.p1_alu_useRm, use_mem_rn: mem_acc,
                 store: bus.p1_memWrite};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p2  <= '0;
      p3  <= '0;
      p4  <= '0;
      cnt <= '0;
    end else begin
      p2 <= p2_nxt;
      p3 <= p2.s;
      p4 <= p3;
      if (stall && !(&cnt)) cnt <= cnt + 1'b1;
    end
  fwd_select u_alu_rn (.src(p2.alu_rn), .use_src(p2.use_rn),     .p3(p3), .p4(p4), .sel(bus.f_alu_reg_rn_sel));
  fwd_select u_alu_rm (.src(p2.alu_rm), .use_src(p2.use_rm),     .p3(p3), .p4(p4), .sel(bus.f_alu_reg_rm_sel));
  fwd_select u_mem_rn (.src(p2.mem_rn), .use_src(p2.use_mem_rn), .p3(p3), .p4(p4), .sel(bus.f_mem_reg_rn_sel));
  assign bus.stall            = stall;
  assign bus.bubble_p2        = bubble;
  assign bus.f_mem_reg_rd_sel = p2.store & alu_hit(p3, p2.s.mem_rd);
  assign bus.dual_write_err   = p2.s.valid & p2.s.alu_we & p2.s.load_we & (p2.s.alu_rd == p2.s.mem_rd);
  assign bus.stall_count      = cnt;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed and random checks against a packet-level pipeline model.
module tb_hazard_fwd_ctrl;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct { int v, rn, rm, rd, use_rm, we, mrn, mrd, ld, st; } pkt_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  hazard_fwd_ctrl_if #(.CNT_W(CW)) bus();
  hazard_fwd_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  pkt_t m [2:4];
  pkt_t cur, p;
  int fl, cnt, n_chk, n_pass, f, s;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic pkt_t mk(input int rd, rn, rm, use_rm, we, mrd, mrn, ld, st);
    pkt_t q;
    q = '{v: 1, rn: rn, rm: rm, rd: rd, use_rm: use_rm, we: we, mrn: mrn, mrd: mrd, ld: ld, st: st};
    return q;
  endfunction
  function automatic pkt_t nop();
    pkt_t q = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    q.v = 0;
    return q;
  endfunction
  function automatic pkt_t alu(input int rd, rn, rm);
    return mk(rd, rn, rm, 1, 1, 0, 0, 0, 0);
  endfunction
  function automatic pkt_t ldp(input int rd, base);
    return mk(0, 0, 0, 0, 0, rd, base, 1, 0);
  endfunction
  function automatic pkt_t stp(input int rd, base);
    return mk(0, 0, 0, 0, 0, rd, base, 0, 1);
  endfunction
  function automatic pkt_t rnd();
    pkt_t q;
    int k = $urandom_range(0, 2);
    q = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), k == 1, k == 2);
    q.v = ($urandom_range(0, 7) != 0);
    return q;
  endfunction

  // who produces register r in a packet: ALU result, or load data not overridden by the ALU
  function automatic bit aw(input pkt_t q, input int r);
    return q.v != 0 && q.we != 0 && q.rd == r;
  endfunction
  function automatic bit lw(input pkt_t q, input int r);
    return q.v != 0 && q.ld != 0 && q.mrd == r && !(q.we != 0 && q.rd == q.mrd);
  endfunction
  function automatic int exp_stall();
    if (cur.v == 0 || fl != 0) return 0;
    if (lw(m[2], cur.rn) || (cur.use_rm != 0 && lw(m[2], cur.rm)) ||
        ((cur.ld != 0 || cur.st != 0) && lw(m[2], cur.mrn))) return 1;
    return int'(cur.st != 0 && (lw(m[2], cur.mrd) || aw(m[3], cur.mrd) ||
                (m[3].v != 0 && m[3].ld != 0 && m[3].mrd == cur.mrd)));
  endfunction
  function automatic int fsel(input bit used, input int r);
    if (!used || m[2].v == 0) return 0;
    if (aw(m[3], r)) return 1;
    if (aw(m[4], r)) return 2;
    if (lw(m[4], r)) return 3;
    return 0;
  endfunction

  task automatic mreset();
    for (int k = 2; k <= 4; k++) m[k] = nop();
    cnt = 0;
  endtask

  task automatic drive(input pkt_t q, input int fi);
    int es;
    @(negedge clk);
    cur = q;
    fl  = fi;
    bus.p1_valid        = 1'(q.v);
    bus.p1_alu_rn       = 3'(q.rn);
    bus.p1_alu_rm       = 3'(q.rm);
    bus.p1_alu_rd       = 3'(q.rd);
    bus.p1_alu_useRm    = 1'(q.use_rm);
    bus.p1_alu_regWrite = 1'(q.we);
    bus.p1_mem_rn       = 3'(q.mrn);
    bus.p1_mem_rd       = 3'(q.mrd);
    bus.p1_memRead      = 1'(q.ld);
    bus.p1_memWrite     = 1'(q.st);
    bus.flush           = 1'(fi);
    #1;
    es = exp_stall();
    chk("stall", int'(bus.stall), es);
    chk("bubble_p2", int'(bus.bubble_p2), int'(es != 0 || fi != 0));
    chk("rn_sel", int'(bus.f_alu_reg_rn_sel), fsel(1, m[2].rn));
    chk("rm_sel", int'(bus.f_alu_reg_rm_sel), fsel(m[2].use_rm != 0, m[2].rm));
    chk("mem_rn_sel", int'(bus.f_mem_reg_rn_sel), fsel(m[2].ld != 0 || m[2].st != 0, m[2].mrn));
    chk("mem_rd_sel", int'(bus.f_mem_reg_rd_sel), int'(m[2].v != 0 && m[2].st != 0 && aw(m[3], m[2].mrd)));
    chk("dual_write_err", int'(bus.dual_write_err),
        int'(m[2].v != 0 && m[2].we != 0 && m[2].ld != 0 && m[2].rd == m[2].mrd));
    chk("stall_count", int'(bus.stall_count), cnt);
  endtask

  task automatic tick();
    int es = exp_stall();
    @(posedge clk);
    if (es != 0 && cnt < CMAX) cnt++;
    m[4] = m[3];
    m[3] = m[2];
    if (es != 0 || fl != 0) m[2] = nop();
    else m[2] = cur;
  endtask

  task automatic drain();
    repeat (3) begin drive(nop(), 0); tick(); end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    mreset();
    drive(nop(), 0);
    chk("rst_count", int'(bus.stall_count), 0);
    drive(nop(), 1);
    chk("rst_flush_bubble", int'(bus.bubble_p2), 1);
    reset = 1'b1;
    tick();
    drive(ldp(2, 0), 0); tick();
    drive(alu(3, 2, 1), 0);
    chk("lu_stall", int'(bus.stall), 1);
    chk("lu_bubble", int'(bus.bubble_p2), 1);
    tick();
    drive(alu(3, 2, 1), 0);
    chk("lu_release", int'(bus.stall), 0);
    tick();
    drive(nop(), 0);
    chk("lu_fwd_load", int'(bus.f_alu_reg_rn_sel), 3);
    chk("lu_count", int'(bus.stall_count), 1);
    tick();
    drain();
    drive(alu(1, 2, 3), 0); tick();
    drive(alu(4, 1, 5), 0);
    chk("b2b_no_stall", int'(bus.stall), 0);
    tick();
    drive(nop(), 0);
    chk("b2b_fwd_p3", int'(bus.f_alu_reg_rn_sel), 1);
    tick();
    drain();
    drive(ldp(5, 6), 0); tick();
    drive(stp(5, 6), 0); chk("sd_stall1", int'(bus.stall), 1); tick();
    drive(stp(5, 6), 0); chk("sd_stall2", int'(bus.stall), 1); tick();
    drive(stp(5, 6), 0); chk("sd_release", int'(bus.stall), 0); tick();
    drive(nop(), 0); chk("sd_rd_sel", int'(bus.f_mem_reg_rd_sel), 0); tick();
    drain();
    drive(ldp(2, 0), 0); tick();
    drive(alu(3, 2, 1), 1);
    chk("fl_no_stall", int'(bus.stall), 0);
    chk("fl_bubble", int'(bus.bubble_p2), 1);
    tick();
    drive(nop(), 0); chk("fl_count", int'(bus.stall_count), 3); tick();
    drain();
    drive(mk(4, 1, 2, 1, 1, 4, 0, 1, 0), 0); tick();
    drive(alu(5, 4, 4), 0);
    chk("dw_err", int'(bus.dual_write_err), 1);
    chk("dw_no_stall", int'(bus.stall), 0);
    tick();
    drive(nop(), 0); chk("dw_alu_wins", int'(bus.f_alu_reg_rn_sel), 1); tick();
    p = rnd();
    for (int i = 0; i < 1500; i++) begin
      f = int'($urandom_range(0, 15) == 0);
      drive(p, f);
      s = exp_stall();
      tick();
      if (s == 0) p = rnd();
    end
    drain();
    repeat (520) begin
      drive(ldp(5, 6), 0); tick();
      drive(stp(5, 6), 0); tick();
      drive(stp(5, 6), 0); tick();
    end
    drive(nop(), 0); chk("sat_count", int'(bus.stall_count), CMAX); tick();
    drive(ldp(5, 6), 0); tick();
    drive(stp(5, 6), 0);
    chk("pre_rst_stall", int'(bus.stall), 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_drop_stall", int'(bus.stall), 0);
    chk("rst_clear_count", int'(bus.stall_count), 0);
    mreset();
    drive(stp(5, 6), 0);
    reset = 1'b1;
    tick();
    drive(ldp(2, 0), 0); tick();
    drive(alu(3, 2, 1), 0); chk("post_rst_stall", int'(bus.stall), 1); tick();
    drive(nop(), 0); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall performance counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 p1_valid  in  1  decode-stage packet holds a real instruction pair.
REQ-005 p1_alu_rn, p1_alu_rm, p1_alu_rd  in  3 each  ALU-slot source/destination register numbers.
REQ-006 p1_alu_useRm  in  1  ALU slot reads rm (0 when aluSrcB selects the immediate).
REQ-007 p1_alu_regWrite  in  1  ALU slot writes alu_rd.
REQ-008 p1_mem_rn, p1_mem_rd  in  3 each  memory-slot base register and load-dest/store-data register.
REQ-009 p1_memRead, p1_memWrite  in  1 each  load / store in memory slot (never both).
REQ-010 flush  in  1  branch/jump redirect; kills the decode packet.
REQ-011 stall  out  1  hold PC and decode register this cycle.
REQ-012 bubble_p2  out  1  load all-zero control into the ID/EX register this cycle.
REQ-013 f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel  out  2 each  EX forwarding selects: 0 regfile, 1 p3 ALU result, 2 p4 ALU result, 3 p4 load data.
REQ-014 f_mem_reg_rd_sel  out  1  store-data select: 0 regfile, 1 p3 ALU result.
REQ-015 dual_write_err  out  1  both slots of the EX packet write the same register.
REQ-016 stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 The block SHALL keep shadow records of stages p2, p3, p4: valid, alu_rd, alu_we, mem_rd, load_we, plus p2 sources and source-use bits.
REQ-018 Each cycle p2<=p1 fields (or bubble), p3<=p2, p4<=p3; bubble means valid=0 and all write/use bits 0.
REQ-019 Register 0 SHALL be an ordinary register; all 8 registers take part in hazard checks.
REQ-020 Sources used by p1: alu_rn always, alu_rm iff useRm, mem_rn iff memRead|memWrite, mem_rd iff memWrite.
REQ-021 Load-use stall: p1_valid, p2 load_we, and p2 mem_rd equals any used p1 ALU source or mem_rn.
REQ-022 Store-data stall: p1 store with mem_rd equal to p2 load rd, or to any p3 writer rd (ALU or load).
REQ-023 stall and bubble_p2 SHALL be combinational from p1 inputs and p2/p3 shadows; bubble_p2=stall|flush.
REQ-024 flush SHALL force stall=0 and bubble_p2=1 in the same cycle (flush wins over stall).
REQ-025 Forwarding per used p2 source, priority: p3 ALU match -> 1; else p4 ALU match -> 2; else p4 load match -> 3; else 0.
REQ-026 Unused sources and invalid p2 SHALL select 0; f_mem_reg_rd_sel=1 only for p2 store matching p3 ALU rd.
REQ-027 Within one stage, if ALU and load write the same rd, ALU SHALL win for forwarding; dual_write_err=1 while that packet is in p2.
REQ-028 Regfile is write-before-read; a writer in p4 is visible to p1 reads without stall.
REQ-029 stall_count SHALL increment on every cycle with stall=1 and hold at all-ones.

Reset
REQ-030 Reset SHALL clear all shadow records to bubble and stall_count to 0, asynchronously.
REQ-031 During and after reset until a valid packet arrives: stall=0, bubble_p2=flush, all selects 0, dual_write_err=0.
REQ-032 Reset mid-stall SHALL drop the stall immediately; no pending hazard survives reset.

Structure
REQ-033 Select encodings (SEL_RF, SEL_P3_ALU, SEL_P4_ALU, SEL_P4_LD) and the stage-record type SHALL live in the shared pipeline package.
REQ-034 One sub-module, fwd_select, SHALL compute one 2-bit select from a source register, use bit and p3/p4 records; instantiated three times.

Verification
REQ-035 ALU r1<-r2+r3 then ALU r4<-r1+r5 back-to-back -> no stall; f_alu_reg_rn_sel=1 when the second is in EX.
REQ-036 Load r2<-[r0+4] then ALU r3<-r2+r1 -> exactly 1 stall cycle, bubble_p2=1; then f_alu_reg_rn_sel=3; stall_count=1.
REQ-037 Load r5 then store r5->[r6] -> 2 stall cycles, then f_mem_reg_rd_sel=0.
REQ-038 Load-use hazard with flush=1 same cycle -> stall=0, bubble_p2=1, stall_count unchanged.
REQ-039 Packet with ALU rd=r4 and load rd=r4, consumer of r4 next -> dual_write_err=1, consumer select=1 (ALU wins).
REQ-040 Force 65540 consecutive stall cycles -> stall_count=16'hFFFF; reset low mid-stall -> stall=0, stall_count=0 immediately.
